// File: rtl/mem_arb32.sv
// Single-port memory arbiter: shares one bus between instruction fetch (IF) and load/store (LS),
// one outstanding transaction at a time. Define MEM_ARB32_RR_EN for round-robin arbitration.
module mem_arb32 #(
    parameter  int WIDTH = 32,
    localparam int STRB  = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [WIDTH-1:0] if_addr,
    output logic             if_rvalid,
    output logic [WIDTH-1:0] if_rdata,
    input  logic             ls_valid,
    output logic             ls_ready,
    input  logic [WIDTH-1:0] ls_addr,
    input  logic             ls_we,
    input  logic [STRB-1:0]  ls_wstrb,
    input  logic [WIDTH-1:0] ls_wdata,
    output logic             ls_rvalid,
    output logic [WIDTH-1:0] ls_rdata,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_we,
    output logic [STRB-1:0]  mem_wstrb,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t state, state_nxt;
    logic   owner_ls;
    logic   grant_ls, grant_if, accept;

`ifdef MEM_ARB32_RR_EN
    logic   last_ls;
`endif

    always_comb begin
        state_nxt = state;
        grant_ls  = 1'b0;
        grant_if  = 1'b0;
        case (state)
            IDLE: begin
                // Grants are suppressed during reset so nothing is handshaken that will not be latched
                if (!rst) begin
                    if (ls_valid && if_valid) begin
`ifdef MEM_ARB32_RR_EN
                        grant_ls = !last_ls;
`else
                        grant_ls = 1'b1;
`endif
                        grant_if = !grant_ls;
                    end else begin
                        grant_ls = ls_valid;
                        grant_if = if_valid;
                    end
                    if (ls_valid || if_valid)
                        state_nxt = ISSUE;
                end
            end
            ISSUE:   if (mem_ready)  state_nxt = WAIT;
            WAIT:    if (mem_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign accept    = grant_ls | grant_if;
    assign if_ready  = grant_if;
    assign ls_ready  = grant_ls;
    assign mem_valid = (state == ISSUE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner_ls  <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            ls_rvalid <= 1'b0;
            ls_rdata  <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            if (accept) begin
                owner_ls  <= grant_ls;
                mem_addr  <= grant_ls ? ls_addr : if_addr;
                mem_we    <= grant_ls & ls_we;
                mem_wstrb <= grant_ls ? ls_wstrb : '0;
                mem_wdata <= grant_ls ? ls_wdata : '0;
            end
            if (mem_rvalid) begin
                if (state == WAIT) begin
                    if (owner_ls) begin
                        ls_rvalid <= 1'b1;
                        ls_rdata  <= mem_we ? '0 : mem_rdata;
                    end else begin
                        if_rvalid <= 1'b1;
                        if_rdata  <= mem_rdata;
                    end
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

`ifdef MEM_ARB32_RR_EN
    always_ff @(posedge clk) begin
        if (rst)
            last_ls <= 1'b0;
        else if (accept)
            last_ls <= grant_ls;
    end
`endif

endmodule

// File: tb/tb_mem_arb32.sv
// Self-checking bench for mem_arb32: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_arb32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [31:0] if_addr = '0;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_valid = 1'b0;
    logic        ls_ready;
    logic [31:0] ls_addr = '0;
    logic        ls_we = 1'b0;
    logic [3:0]  ls_wstrb = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    mem_arb32 #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_addr(ls_addr),
        .ls_we(ls_we), .ls_wstrb(ls_wstrb), .ls_wdata(ls_wdata),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit done  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: the single in-flight request plus per-requester response state
    typedef struct {
        bit          ls;
        bit          we;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        cur;
    bit          m_have, m_issued, m_rv_if, m_rv_ls, m_err;
    logic [31:0] m_if_rdata, m_ls_rdata;
`ifdef MEM_ARB32_RR_EN
    bit          m_last_ls;
`endif

    task automatic model_reset();
        m_have     = 1'b0;
        m_issued   = 1'b0;
        m_rv_if    = 1'b0;
        m_rv_ls    = 1'b0;
        m_err      = 1'b0;
        m_if_rdata = '0;
        m_ls_rdata = '0;
        cur.ls     = 1'b0;
        cur.we     = 1'b0;
        cur.wstrb  = '0;
        cur.addr   = '0;
        cur.wdata  = '0;
`ifdef MEM_ARB32_RR_EN
        m_last_ls  = 1'b0;
`endif
    endtask

    initial model_reset();

    always @(negedge clk) begin : compare
        bit g_ls, g_if, resp, issue;
        if (!done) begin
            g_ls = 1'b0;
            g_if = 1'b0;
            if (!rst && !m_have) begin
                if (ls_valid && if_valid) begin
`ifdef MEM_ARB32_RR_EN
                    g_ls = !m_last_ls;
`else
                    g_ls = 1'b1;
`endif
                    g_if = !g_ls;
                end else begin
                    g_ls = ls_valid;
                    g_if = if_valid;
                end
            end

            chk("if_ready",  32'(if_ready),  32'(g_if));
            chk("ls_ready",  32'(ls_ready),  32'(g_ls));
            chk("if_rvalid", 32'(if_rvalid), 32'(m_rv_if));
            chk("ls_rvalid", 32'(ls_rvalid), 32'(m_rv_ls));
            chk("if_rdata",  if_rdata,       m_if_rdata);
            chk("ls_rdata",  ls_rdata,       m_ls_rdata);
            chk("busy",      32'(busy),      32'(m_have));
            chk("err",       32'(err),       32'(m_err));
            chk("mem_valid", 32'(mem_valid), 32'(m_have && !m_issued));
            if (m_have && !m_issued) begin
                chk("mem_addr",  mem_addr,       cur.addr);
                chk("mem_we",    32'(mem_we),    32'(cur.we));
                chk("mem_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
                chk("mem_wdata", mem_wdata,      cur.wdata);
            end

            if (rst) begin
                model_reset();
            end else begin
                resp    = m_have && m_issued && mem_rvalid;
                issue   = m_have && !m_issued && mem_ready;
                m_rv_if = 1'b0;
                m_rv_ls = 1'b0;
                if (mem_rvalid && !(m_have && m_issued))
                    m_err = 1'b1;
                if (resp) begin
                    if (cur.ls) begin
                        m_rv_ls    = 1'b1;
                        m_ls_rdata = cur.we ? 32'h0 : mem_rdata;
                    end else begin
                        m_rv_if    = 1'b1;
                        m_if_rdata = mem_rdata;
                    end
                    m_have = 1'b0;
                end
                if (issue)
                    m_issued = 1'b1;
                if (g_ls || g_if) begin
                    m_have    = 1'b1;
                    m_issued  = 1'b0;
                    cur.ls    = g_ls;
                    cur.addr  = g_ls ? ls_addr : if_addr;
                    cur.we    = g_ls && ls_we;
                    cur.wstrb = g_ls ? ls_wstrb : 4'h0;
                    cur.wdata = g_ls ? ls_wdata : 32'h0;
`ifdef MEM_ARB32_RR_EN
                    m_last_ls = g_ls;
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int       nvalid;
        bit [3:0] grants;
        bit [3:0] exp_grants;

        // Reset state
        @(negedge clk);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_mem_valid", 32'(mem_valid), 32'h0);
        chk("rst_err",       32'(err),       32'h0);
        chk("rst_if_rdata",  if_rdata,       32'h0);
        chk("rst_mem_addr",  mem_addr,       32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Single IF read at minimum latency
        if_valid = 1'b1;
        if_addr  = 32'h8000_0000;
        @(negedge clk);
        chk("t1_if_ready", 32'(if_ready), 32'h1);
        chk("t1_ls_ready", 32'(ls_ready), 32'h0);
        tick();
        if_valid  = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("t1_mem_valid", 32'(mem_valid), 32'h1);
        chk("t1_mem_addr",  mem_addr,       32'h8000_0000);
        tick();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0413;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        @(negedge clk);
        chk("t1_if_rvalid", 32'(if_rvalid), 32'h1);
        chk("t1_if_rdata",  if_rdata,       32'h0000_0413);
        chk("t1_ls_rvalid", 32'(ls_rvalid), 32'h0);
        tick();
        @(negedge clk);
        chk("t1_if_rvalid_pulse", 32'(if_rvalid), 32'h0);
        tick();

        // LS write with mem_ready held off two cycles
        ls_valid = 1'b1;
        ls_we    = 1'b1;
        ls_wstrb = 4'hF;
        ls_wdata = 32'hDEAD_BEEF;
        ls_addr  = 32'h8000_0100;
        @(negedge clk);
        chk("t2_ls_ready", 32'(ls_ready), 32'h1);
        tick();
        ls_valid = 1'b0;
        ls_we    = 1'b0;
        ls_wstrb = '0;
        ls_wdata = '0;
        ls_addr  = '0;
        nvalid   = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) mem_ready = 1'b1;
            @(negedge clk);
            if (mem_valid && mem_addr == 32'h8000_0100 && mem_we &&
                mem_wstrb == 4'hF && mem_wdata == 32'hDEAD_BEEF)
                nvalid++;
            tick();
        end
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        @(negedge clk);
        chk("t2_valid_cycles", 32'(nvalid),    32'd3);
        chk("t2_valid_drop",   32'(mem_valid), 32'h0);
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        @(negedge clk);
        chk("t2_ls_rvalid", 32'(ls_rvalid), 32'h1);
        chk("t2_ls_rdata",  ls_rdata,       32'h0);
        chk("t2_if_rdata",  if_rdata,       32'h0000_0413);
        tick();

        // LS read with a stalled response; IF raises and drops valid while busy
        ls_valid = 1'b1;
        ls_addr  = 32'h0000_2000;
        tick();
        ls_valid = 1'b0;
        if_valid = 1'b1;
        if_addr  = 32'h0000_0040;
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        if_valid  = 1'b0;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_0001;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        @(negedge clk);
        chk("t2b_ls_rvalid", 32'(ls_rvalid), 32'h1);
        chk("t2b_ls_rdata",  ls_rdata,       32'hCAFE_0001);
        chk("t2b_busy",      32'(busy),      32'h0);
        tick();

        // Spurious response in IDLE
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("t3_err_before", 32'(err), 32'h0);
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        @(negedge clk);
        chk("t3_err",       32'(err),       32'h1);
        chk("t3_if_rvalid", 32'(if_rvalid), 32'h0);
        chk("t3_ls_rvalid", 32'(ls_rvalid), 32'h0);
        repeat (3) tick();
        @(negedge clk);
        chk("t3_err_sticky", 32'(err), 32'h1);
        tick();

        // Reset while waiting for a response
        if_valid = 1'b1;
        if_addr  = 32'h8000_0010;
        tick();
        if_valid  = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("t4_busy_wait", 32'(busy), 32'h1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t4_busy",     32'(busy),      32'h0);
        chk("t4_mem_valid",32'(mem_valid), 32'h0);
        chk("t4_err",      32'(err),       32'h0);
        chk("t4_if_rdata", if_rdata,       32'h0);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_5555;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        @(negedge clk);
        chk("t4_late_rvalid", 32'(if_rvalid), 32'h0);
        chk("t4_late_err",    32'(err),       32'h1);
        tick();

        // Contention: both requesters valid for four zero-wait rounds
        if_valid  = 1'b1;
        if_addr   = 32'h0000_0100;
        ls_valid  = 1'b1;
        ls_addr   = 32'h0000_0200;
        ls_we     = 1'b0;
        mem_ready = 1'b1;
        grants    = '0;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            grants[r] = ls_ready;
            chk($sformatf("t5_one_ready_r%0d", r), 32'(ls_ready ^ if_ready), 32'h1);
            tick();
            tick();
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h0000_1000 + 32'(r);
            tick();
            mem_rvalid = 1'b0;
        end
        if_valid  = 1'b0;
        ls_valid  = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
`ifdef MEM_ARB32_RR_EN
        exp_grants = 4'b0101;
`else
        exp_grants = 4'b1111;
`endif
        for (int r = 0; r < 4; r++)
            chk($sformatf("t5_grant_ls_r%0d", r), 32'(grants[r]), 32'(exp_grants[r]));
        @(negedge clk);
        chk("t5_last_rvalid", 32'(ls_rvalid | if_rvalid), 32'h1);
        repeat (3) tick();

        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
